fpu_issue_ctrl: RTL and testbench

//  Issue/collect front end for the fpu execution unit. Buffers op requests in a small FIFO.

---
 rtl/fpu_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: request FIFO plus issue/collect FSM in front of the fpu.
// Optional feature macro: FPU_ILLEGAL_OP_CHK_EN. When it is defined, a popped op of
// 4'b0000 is answered directly with rsp_err=1 and a zero result. When it is not
// defined, op 4'b0000 is issued like any short op.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | nothing in flight; pops the FIFO head when one is present
// S_ISSUE | operands/control presented to fpu, latency counter loaded
// S_WAIT  | counting down fpu latency; result captured when cnt==1
// S_RESP  | response held on rsp_* until rsp_ready
module fpu_issue_ctrl #(
  parameter int OPW      = 5,
  parameter int RESW     = 32,
  parameter int TAGW     = 4,
  parameter int DEPTH    = 4,
  parameter int EU_LAT   = 1,
  parameter int LONG_LAT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_a,
  input  logic [OPW-1:0]  req_b,
  input  logic [3:0]      req_op,
  input  logic [TAGW-1:0] req_tag,
  output logic [OPW-1:0]  eu_op_a,
  output logic [OPW-1:0]  eu_op_b,
  output logic [3:0]      eu_ctrl,
  input  logic [RESW-1:0] eu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [RESW-1:0] rsp_result,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err,
  output logic            busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = $clog2(LONG_LAT + 1);
  localparam int EW = 2 * OPW + 4 + TAGW;

  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_SQRT = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, push, pop;
  logic [OPW-1:0]  head_a, head_b;
  logic [3:0]      head_op;
  logic [TAGW-1:0] head_tag;
  logic            head_illegal;
  logic [TAGW-1:0] cur_tag;
  logic [LW-1:0]   cnt;
  logic            is_long;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  assign {head_a, head_b, head_op, head_tag} = fifo_mem[rd_ptr];
  assign busy      = !empty || (state != S_IDLE);
  assign is_long   = (eu_ctrl == OP_DIV) || (eu_ctrl == OP_SQRT);

`ifdef FPU_ILLEGAL_OP_CHK_EN
  assign head_illegal = (head_op == 4'b0000);
`else
  assign head_illegal = 1'b0;
`endif

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_a, req_b, req_op, req_tag};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and FIFO pop; RESP pops directly into ISSUE to avoid an IDLE bubble
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = head_illegal ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == LW'(1)) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = head_illegal ? S_RESP : S_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, latency counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      eu_op_a    <= '0;
      eu_op_b    <= '0;
      eu_ctrl    <= '0;
      cur_tag    <= '0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= (state_nxt == S_RESP);
      if (pop) begin
        eu_op_a <= head_a;
        eu_op_b <= head_b;
        eu_ctrl <= head_op;
        cur_tag <= head_tag;
        if (head_illegal) begin
          rsp_result <= '0;
          rsp_tag    <= head_tag;
          rsp_err    <= 1'b1;
        end
      end else if (state_nxt == S_IDLE) begin
        // operands are left as they were; only the control code is parked
        eu_ctrl <= 4'b0000;
      end
      if (state == S_ISSUE) begin
        cnt <= is_long ? LW'(LONG_LAT) : LW'(EU_LAT);
      end else if (state == S_WAIT) begin
        cnt <= cnt - LW'(1);
        if (cnt == LW'(1)) begin
          rsp_result <= eu_result;
          rsp_tag    <= cur_tag;
          rsp_err    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a behavioural fpu stub whose result is only valid once
// its inputs have been stable for the op latency, and a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  localparam int OPW = 5, RESW = 32, TAGW = 4, DEPTH = 4, EU_LAT = 1, LONG_LAT = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [OPW-1:0]  req_a, req_b;
  logic [3:0]      req_op;
  logic [TAGW-1:0] req_tag;
  logic [OPW-1:0]  eu_op_a, eu_op_b;
  logic [3:0]      eu_ctrl;
  logic [RESW-1:0] eu_result;
  logic            rsp_valid, rsp_ready;
  logic [RESW-1:0] rsp_result;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;
  logic            busy;

  fpu_issue_ctrl #(.OPW(OPW), .RESW(RESW), .TAGW(TAGW), .DEPTH(DEPTH),
                   .EU_LAT(EU_LAT), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .eu_op_a(eu_op_a), .eu_op_b(eu_op_b), .eu_ctrl(eu_ctrl), .eu_result(eu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [RESW-1:0] res;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] fpu_ref(input logic [4:0] a, input logic [4:0] b,
                                          input logic [3:0] op);
    logic [31:0] r;
    r = '0;
    case (op)
      4'b0001: r = 32'(a) + 32'(b);
      4'b0010: r = 32'(a) - 32'(b);
      4'b0011: r = (a > b) ? 32'd1 : 32'd0;
      4'b1101: r = (b != 5'd0) ? 32'(a / b) : 32'd0;
      4'b1110: for (int i = 0; i < 6; i++) if (i * i <= int'(a)) r = 32'(i);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int op_lat(input logic [3:0] op);
    return (op == 4'b1101 || op == 4'b1110) ? LONG_LAT : EU_LAT;
  endfunction

  // fpu stub: age counts cycles since the operand/control inputs last changed
  logic [2*OPW+3:0] last_eu = '0;
  int               age = 0;
  always begin
    @(posedge clk);
    #1;
    if ({eu_op_a, eu_op_b, eu_ctrl} !== last_eu) begin
      last_eu = {eu_op_a, eu_op_b, eu_ctrl};
      age = 0;
    end else if (age < 1000) begin
      age = age + 1;
    end
  end
  always_comb eu_result = (age >= op_lat(eu_ctrl)) ? fpu_ref(eu_op_a, eu_op_b, eu_ctrl)
                                                   : 32'hDEAD_BEEF;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one request, wait for acceptance (bounded), record its expected response
  task automatic send(input logic [4:0] a, input logic [4:0] b, input logic [3:0] op,
                      input logic [3:0] tag);
    int   waited;
    exp_t e;
    waited = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_tag = tag;
    while (!req_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: req_ready got 0 required 1 for tag %0d", tag);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    e.tag = tag;
    e.res = fpu_ref(a, b, op);
    e.err = 1'b0;
`ifdef FPU_ILLEGAL_OP_CHK_EN
    if (op == 4'b0000) begin
      e.res = '0;
      e.err = 1'b1;
    end
`endif
    exp_q.push_back(e);
  endtask

  // cyc=1 denotes the cycle after the call point's edge
  task automatic wait_rsp(output int cyc, output bit seen);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    seen = rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    n_checks++;
    if ({rsp_valid, rsp_err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b required 000", {rsp_valid, rsp_err, busy}); end
    n_checks++;
    if ({eu_op_a, eu_op_b, eu_ctrl} !== 14'h0) begin n_fail++; $display("FAIL reset_eu: got %h required 0", {eu_op_a, eu_op_b, eu_ctrl}); end
    n_checks++;
    if ({rsp_result, rsp_tag} !== 36'h0) begin n_fail++; $display("FAIL reset_rsp: got %h required 0", {rsp_result, rsp_tag}); end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({req_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL reset_release: ready/busy got %b required 10", {req_ready, busy}); end
  endtask

  task automatic test_add();
    int cyc; bit seen; exp_t e;
    send(5'h01, 5'h12, 4'b0001, 4'd3);
    wait_rsp(cyc, seen);
    n_checks++;
    if (!seen || cyc != 3 + EU_LAT) begin n_fail++; $display("FAIL add_latency: got %0d cycles required %0d", cyc, 3 + EU_LAT); end
    n_checks++;
    if (rsp_result !== 32'h13) begin n_fail++; $display("FAIL add_result: got %h required 00000013", rsp_result); end
    n_checks++;
    if ({rsp_tag, rsp_err} !== {4'd3, 1'b0}) begin n_fail++; $display("FAIL add_tag_err: got %h/%b required 3/0", rsp_tag, rsp_err); end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL add_sb: response with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({rsp_tag, rsp_result, rsp_err} !== {e.tag, e.res, e.err}) begin n_fail++; $display("FAIL add_sb: got %h/%h required %h/%h", rsp_tag, rsp_result, e.tag, e.res); end
    end
    tick();
    n_checks++;
    if ({rsp_valid, busy, eu_ctrl} !== 6'h0) begin n_fail++; $display("FAIL add_release: valid/busy/ctrl got %b required 0", {rsp_valid, busy, eu_ctrl}); end
  endtask

  task automatic test_div_latency();
    int cyc; exp_t e;
    send(5'h12, 5'h03, 4'b1101, 4'd5);
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      if (cyc >= 2) begin
        n_checks++;
        if ({eu_op_a, eu_op_b, eu_ctrl} !== {5'h12, 5'h03, 4'b1101}) begin n_fail++; $display("FAIL div_eu_stable: cycle %0d got %h required %h", cyc, {eu_op_a, eu_op_b, eu_ctrl}, {5'h12, 5'h03, 4'b1101}); end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (!rsp_valid || cyc != 3 + LONG_LAT) begin n_fail++; $display("FAIL div_latency: got %0d cycles required %0d", cyc, 3 + LONG_LAT); end
    n_checks++;
    if ({rsp_result, rsp_tag} !== {32'd6, 4'd5}) begin n_fail++; $display("FAIL div_result: got %h/%h required 6/5", rsp_result, rsp_tag); end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tick();
    n_checks++;
    if ({eu_ctrl, eu_op_a} !== {4'b0000, 5'h12}) begin n_fail++; $display("FAIL div_idle_eu: got %h required %h", {eu_ctrl, eu_op_a}, {4'b0000, 5'h12}); end
  endtask

  task automatic test_backpressure();
    int cyc; bit seen; exp_t e;
    rsp_ready = 1'b0;
    send(5'h03, 5'h04, 4'b0001, 4'd0);
    send(5'h1f, 5'h02, 4'b0010, 4'd1);
    send(5'h07, 5'h08, 4'b0011, 4'd2);
    send(5'h1f, 5'h05, 4'b1101, 4'd3);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_3q: got %b required 1", req_ready); end
    send(5'h19, 5'h00, 4'b1110, 4'd4);
    n_checks++;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b required 0", req_ready); end
    req_valid = 1'b1; req_a = 5'h01; req_b = 5'h01; req_op = 4'b0001; req_tag = 4'd15;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({req_ready, rsp_valid, rsp_tag} !== {1'b0, 1'b1, 4'd0}) begin n_fail++; $display("FAIL bp_hold: ready/valid/tag got %b/%b/%0d required 0/1/0", req_ready, rsp_valid, rsp_tag); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(cyc, seen);
      if (!seen || exp_q.size() == 0) begin
        n_checks++; n_fail++; $display("FAIL bp_rsp_missing: response %0d seen=%b sb=%0d", i, seen, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if ({rsp_tag, rsp_result, rsp_err} !== {e.tag, e.res, e.err}) begin n_fail++; $display("FAIL bp_rsp: #%0d got tag %0d res %h required tag %0d res %h", i, rsp_tag, rsp_result, e.tag, e.res); end
      end
      tick();
    end
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_drain: busy/valid got %b required 00", {busy, rsp_valid}); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; exp_t e;
    rsp_ready = 1'b1;
    send(5'h01, 5'h12, 4'b0010, 4'd6);
    send(5'h12, 5'h01, 4'b0011, 4'd7);
    wait_rsp(cyc, seen);
    n_checks++;
    if (!seen || {rsp_result, rsp_tag} !== {32'hFFFF_FFEF, 4'd6}) begin n_fail++; $display("FAIL b2b_first: got %h/%0d required ffffffef/6", rsp_result, rsp_tag); end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    tick();
    wait_rsp(cyc, seen);
    n_checks++;
    if (!seen || cyc != 2 + EU_LAT) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles required %0d", cyc, 2 + EU_LAT); end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL b2b_sb: response with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({rsp_tag, rsp_result} !== {e.tag, e.res} || rsp_result !== 32'd1) begin n_fail++; $display("FAIL b2b_second: got %h/%0d required 1/%0d", rsp_result, rsp_tag, e.tag); end
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bit saw;
    rsp_ready = 1'b1;
    send(5'h1f, 5'h03, 4'b1101, 4'd8);
    send(5'h01, 5'h02, 4'b0001, 4'd9);
    send(5'h03, 5'h03, 4'b0001, 4'd10);
    tick(); tick(); tick();
    n_checks++;
    if ({busy, rsp_valid, eu_ctrl} !== {1'b1, 1'b0, 4'b1101}) begin n_fail++; $display("FAIL rstw_pre: busy/valid/ctrl got %b required 101101", {busy, rsp_valid, eu_ctrl}); end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b0000) begin n_fail++; $display("FAIL rstw_flags: got %b required 0000", {req_ready, rsp_valid, rsp_err, busy}); end
    n_checks++;
    if ({eu_op_a, eu_op_b, eu_ctrl, rsp_result, rsp_tag} !== 50'h0) begin n_fail++; $display("FAIL rstw_data: got %h required 0", {eu_op_a, eu_op_b, eu_ctrl, rsp_result, rsp_tag}); end
    rst = 1'b0;
    exp_q.delete();
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid) saw = 1'b1;
    end
    n_checks++;
    if ({saw, busy} !== 2'b00) begin n_fail++; $display("FAIL rstw_after: saw_rsp/busy got %b required 00", {saw, busy}); end
  endtask

  task automatic test_illegal_op();
    int cyc; bit seen; exp_t e; int lat_exp; logic err_exp;
`ifdef FPU_ILLEGAL_OP_CHK_EN
    lat_exp = 2; err_exp = 1'b1;
`else
    lat_exp = 3 + EU_LAT; err_exp = 1'b0;
`endif
    rsp_ready = 1'b1;
    send(5'h05, 5'h07, 4'b0000, 4'd11);
    wait_rsp(cyc, seen);
    n_checks++;
    if (!seen || cyc != lat_exp) begin n_fail++; $display("FAIL illegal_latency: got %0d cycles required %0d", cyc, lat_exp); end
    n_checks++;
    if ({rsp_err, rsp_result, rsp_tag} !== {err_exp, 32'h0, 4'd11}) begin n_fail++; $display("FAIL illegal_rsp: err/res/tag got %b/%h/%0d required %b/0/11", rsp_err, rsp_result, rsp_tag, err_exp); end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL illegal_sb: response with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({rsp_tag, rsp_result, rsp_err} !== {e.tag, e.res, e.err}) begin n_fail++; $display("FAIL illegal_sb: got %h/%h/%b required %h/%h/%b", rsp_tag, rsp_result, rsp_err, e.tag, e.res, e.err); end
    end
    tick();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL illegal_release: valid/busy got %b required 00", {rsp_valid, busy}); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_div_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    test_illegal_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
